// File: rtl/rmap_wb_pkg.sv
// Shared types and the round-robin selection helper for the RMAP Wishbone arbiter.
package rmap_wb_pkg;

    localparam int WB_ADR_WIDTH = 32;
    localparam int MAX_MASTERS  = 8;

    typedef enum logic {IDLE, OWNED} state_t;

    // One-hot grant for the first requester found searching upward (circularly)
    // from lastIdx+1; only the low n bits of req take part.
    function automatic logic [MAX_MASTERS-1:0] rrNext(input logic [MAX_MASTERS-1:0] req,
                                                      input int unsigned lastIdx,
                                                      input int unsigned n);
        logic [MAX_MASTERS-1:0] gnt;
        logic [2:0]             idx;
        gnt = '0;
        for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
            idx = 3'((lastIdx + k) % n);
            if (k <= n && gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rmap_wb_watchdog.sv
// Stall watchdog: counts stb cycles with neither ack nor err and emits a
// one-cycle expiry pulse at TIMEOUT_CYCLES-1, then restarts.
module rmap_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             stalled;

    assign stalled = stb && !ack && !err;
    assign timeout = stalled && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst)                  cnt <= '0;
        else if (!stalled || timeout) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/rmap_wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter; grant is held for a master's whole cyc.
// Optional stall watchdog enabled by defining RMAP_WB_ARB_TIMEOUT_EN.
module rmap_wb_arbiter
    import rmap_wb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_MASTERS-1:0]                mCycIn,
    input  logic [NUM_MASTERS-1:0]                mStbIn,
    input  logic [NUM_MASTERS-1:0]                mWeIn,
    input  logic [NUM_MASTERS*WB_ADR_WIDTH-1:0]   mAdrIn,
    input  logic [NUM_MASTERS*(BUS_WIDTH/8)-1:0]  mSelIn,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0]      mDatIn,
    output logic [NUM_MASTERS-1:0]                mAckOut,
    output logic [NUM_MASTERS-1:0]                mErrOut,
    output logic [BUS_WIDTH-1:0]                  mDatOut,
    output logic                                  sCycOut,
    output logic                                  sStbOut,
    output logic                                  sWeOut,
    output logic [WB_ADR_WIDTH-1:0]               sAdrOut,
    output logic [BUS_WIDTH/8-1:0]                sSelOut,
    output logic [BUS_WIDTH-1:0]                  sDatOut,
    input  logic [BUS_WIDTH-1:0]                  sDatIn,
    input  logic                                  sAckIn,
    input  logic                                  sErrIn,
    output logic [NUM_MASTERS-1:0]                grantOut,
    output logic                                  busyOut,
    output logic                                  timeoutOut
);

    localparam int SEL_W = BUS_WIDTH / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [IDX_W-1:0]       last_idx, last_idx_nxt;
    logic [MAX_MASTERS-1:0] req_ext, rr_gnt;
    logic                   timeout_pulse;

    always_comb begin
        req_ext = '0;
        for (int i = 0; i < NUM_MASTERS; i++) req_ext[i] = mCycIn[i];
        rr_gnt = rrNext(req_ext, 32'(last_idx), NUM_MASTERS);
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_idx_nxt = last_idx;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (|mCycIn) begin
                    state_nxt = OWNED;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        grant_nxt[i] = rr_gnt[i];
                        if (rr_gnt[i]) last_idx_nxt = IDX_W'(i);
                    end
                end
            end
            OWNED: begin
                // Release on the owner's cyc drop leaves one dead cycle in IDLE.
                if (!(|(mCycIn & grant))) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_idx <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_idx <= last_idx_nxt;
        end
    end

    // AND-OR mux on the one-hot grant: a zero grant forces the whole slave bus low.
    always_comb begin
        sCycOut = 1'b0;
        sStbOut = 1'b0;
        sWeOut  = 1'b0;
        sAdrOut = '0;
        sSelOut = '0;
        sDatOut = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                sCycOut = sCycOut | mCycIn[i];
                sStbOut = sStbOut | mStbIn[i];
                sWeOut  = sWeOut  | mWeIn[i];
                sAdrOut = sAdrOut | mAdrIn[WB_ADR_WIDTH*i +: WB_ADR_WIDTH];
                sSelOut = sSelOut | mSelIn[SEL_W*i +: SEL_W];
                sDatOut = sDatOut | mDatIn[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

`ifdef RMAP_WB_ARB_TIMEOUT_EN
    rmap_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stb     (sStbOut),
        .ack     (sAckIn),
        .err     (sErrIn),
        .timeout (timeout_pulse)
    );
`else
    assign timeout_pulse = 1'b0;
`endif

    assign mAckOut    = grant & mCycIn & {NUM_MASTERS{sAckIn}};
    assign mErrOut    = (grant & mCycIn & {NUM_MASTERS{sErrIn}}) | (grant & {NUM_MASTERS{timeout_pulse}});
    assign mDatOut    = sDatIn;
    assign grantOut   = grant;
    assign busyOut    = (state == OWNED);
    assign timeoutOut = timeout_pulse;

endmodule
